// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 8-bit signed radix-2 Booth multiplier among N
// requesters, plus the free-running multiplier it sequences (start/busy, no reset).

module multiplier (
  input  logic        clk,
  input  logic        start,
  input  logic [7:0]  mc,
  input  logic [7:0]  mp,
  output logic [15:0] prod,
  output logic        busy
);
  logic [8:0] acc;
  logic [8:0] m;
  logic [7:0] q;
  logic       q_1;
  logic [3:0] cnt;
  logic [8:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Keeps stepping whenever start is low; the result is only valid while cnt == 8.
  always_ff @(posedge clk) begin
    if (start) begin
      acc <= '0;
      m   <= {mc[7], mc};
      q   <= mp;
      q_1 <= 1'b0;
      cnt <= '0;
    end else begin
      {acc, q, q_1} <= {sum[8], sum, q};
      cnt           <= cnt + 4'd1;
    end
  end

  assign busy = (cnt != 4'd8);
  assign prod = {acc[7:0], q};
endmodule

module mult_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] mc_in,
  input  logic [8*N-1:0] mp_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [IDW-1:0] done_id,
  output logic [15:0]    prod_out,
  output logic           arb_busy
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, cur_id, winner, rr_nxt;
  logic [IDW:0]   idx;
  logic           found;
  logic [7:0]     op_mc, op_mp;
  logic [3:0]     step;
  logic           err;
  logic           grant, capture, err_hit;
  logic           mul_start, mul_busy;
  logic [15:0]    mul_prod;

  multiplier u_mul (
    .clk   (clk),
    .start (mul_start),
    .mc    (op_mc),
    .mp    (op_mp),
    .prod  (mul_prod),
    .busy  (mul_busy)
  );

  // First set request at or after rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (!found && req[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  assign rr_nxt = (winner == IDW'(N-1)) ? '0 : winner + 1'b1;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    err_hit   = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE: if (found) begin
        grant     = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        mul_start = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (!mul_busy || step == 4'd8) begin
        // Capture on the first busy-low cycle; a disagreement with our own count flags err.
        capture   = 1'b1;
        err_hit   = mul_busy || (step != 4'd8);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_id   <= '0;
      op_mc    <= '0;
      op_mp    <= '0;
      step     <= '0;
      err      <= 1'b0;
      gnt      <= '0;
      done     <= '0;
      done_id  <= '0;
      prod_out <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= '0;
      done  <= '0;
      if (grant) begin
        gnt    <= N'(1) << winner;
        cur_id <= winner;
        rr_ptr <= rr_nxt;
        op_mc  <= mc_in[{winner, 3'b000} +: 8];
        op_mp  <= mp_in[{winner, 3'b000} +: 8];
        step   <= '0;
      end
      if (state == RUN && !capture) step <= step + 4'd1;
      if (capture) begin
        prod_out <= mul_prod;
        done     <= N'(1) << cur_id;
        done_id  <= cur_id;
        if (err_hit) err <= 1'b1;
      end
    end
  end

  assign arb_busy = (state != IDLE);
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed steps plus random traffic checked against a
// cycle-count model of grants, completions and products.

module tb_mult_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] mc_in, mp_in;
  logic [N-1:0]   gnt, done;
  logic [IDW-1:0] done_id;
  logic [15:0]    prod_out;
  logic           arb_busy;

  mult_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mc_in    (mc_in),
    .mp_in    (mp_in),
    .gnt      (gnt),
    .done     (done),
    .done_id  (done_id),
    .prod_out (prod_out),
    .arb_busy (arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int model_ptr = 0;
  int next_gnt = 0, done_at = -1, pid = 0;
  int maxw = 0;
  logic [15:0] eprod = '0, held_prod = '0;
  int gq[$];
  int gc[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(logic [7:0] a, logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  function automatic int rr_pick(logic [N-1:0] r, int ptr);
    for (int i = 0; i < N; i++)
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic resync();
    next_gnt = cyc + 1;
    done_at  = -1;
  endtask

  task automatic single(int id, logic [7:0] a, logic [7:0] b, string tag);
    int n;
    logic [15:0] expp;
    mc_in[8*id +: 8] = a;
    mp_in[8*id +: 8] = b;
    req = '0;
    req[id] = 1'b1;
    expp = ref_mul(a, b);
    n = 0;
    tick();
    while (gnt == '0 && n < 30) begin tick(); n++; end
    chk({tag, "_gnt"}, gnt, 32'(1) << id);
    chk({tag, "_busy_hi"}, arb_busy, 1);
    req = '0;
    model_ptr = (id + 1) % N;
    n = 0;
    while (done == '0 && n < 30) begin tick(); n++; end
    chk({tag, "_latency"}, n, 10);
    chk({tag, "_done"}, done, 32'(1) << id);
    chk({tag, "_done_id"}, done_id, id);
    chk({tag, "_prod"}, prod_out, expp);
    chk({tag, "_no_gnt_with_done"}, gnt, 0);
    chk({tag, "_busy_lo"}, arb_busy, 0);
    held_prod = expp;
    resync();
  endtask

  // rnd=0 holds req and operands as set; rnd=1 re-randomises idle or just-granted requesters.
  task automatic traffic(int ncyc, bit rnd);
    logic [N-1:0] rq;
    int w;
    int waitc[N];
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int k = 0; k < ncyc; k++) begin
      rq = req;
      tick();
      w = -1;
      if (cyc >= next_gnt && rq != '0) begin
        w = rr_pick(rq, model_ptr);
        model_ptr = (w + 1) % N;
        next_gnt = cyc + 11;
        done_at = cyc + 10;
        pid = w;
        eprod = ref_mul(mc_in[8*w +: 8], mp_in[8*w +: 8]);
        gq.push_back(w);
        gc.push_back(cyc);
      end
      chk("tr_gnt", gnt, (w < 0) ? 0 : (32'(1) << w));
      if (cyc == done_at) begin
        chk("tr_done", done, 32'(1) << pid);
        chk("tr_done_id", done_id, pid);
        chk("tr_prod", prod_out, eprod);
        held_prod = eprod;
      end else begin
        chk("tr_done_idle", done, 0);
        chk("tr_prod_hold", prod_out, held_prod);
      end
      chk("tr_err", dut.err, 0);
      for (int i = 0; i < N; i++) begin
        if (rq[i] && w != i) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > maxw) maxw = waitc[i];
      end
      if (rnd) begin
        for (int i = 0; i < N; i++) begin
          if (w == i || !req[i]) begin
            req[i] = 1'($urandom_range(0, 1));
            mc_in[8*i +: 8] = 8'($urandom);
            mp_in[8*i +: 8] = 8'($urandom);
          end
        end
      end
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_id"}, done_id, 0);
    chk({tag, "_prod"}, prod_out, 0);
    chk({tag, "_busy"}, arb_busy, 0);
    chk({tag, "_err"}, dut.err, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    model_ptr = 0;
    held_prod = '0;
    resync();
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    req   = '0;
    mc_in = '0;
    mp_in = '0;
    #3;
    do_reset();

    single(0, 8'd3, 8'd17, "r0_3x17");
    single(2, 8'hFB, 8'd6, "r2_m5x6");
    single(2, 8'h80, 8'h80, "r2_m128sq");

    // Result must survive the multiplier's internal wrap with no requests pending.
    traffic(20, 1'b0);

    for (int k = 0; k < 6; k++)
      single(int'($urandom_range(0, N-1)), 8'($urandom), 8'($urandom), "rand_single");
    single(1, 8'h7F, 8'h80, "r1_127xm128");

    // All four requesting out of reset.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      mc_in[8*i +: 8] = 8'(i * 7);
      mp_in[8*i +: 8] = 8'd7;
    end
    req = '1;
    tick();
    check_reset_outputs("rst_all");
    rst_n = 1'b1;
    model_ptr = 0;
    held_prod = '0;
    resync();
    gq.delete();
    gc.delete();
    traffic(50, 1'b0);
    chk("all4_ngrants", gq.size(), 5);
    if (gq.size() >= 5) begin
      chk("all4_order0", gq[0], 0);
      chk("all4_order1", gq[1], 1);
      chk("all4_order2", gq[2], 2);
      chk("all4_order3", gq[3], 3);
      chk("all4_order4", gq[4], 0);
      chk("all4_gap", gc[1] - gc[0], 11);
    end
    req = '0;
    traffic(12, 1'b0);

    // Pointer at 2 with requesters 0 and 3 pending.
    single(1, 8'd2, 8'd2, "set_ptr2");
    gq.delete();
    gc.delete();
    mc_in[0 +: 8]  = 8'd9;
    mp_in[0 +: 8]  = 8'hF7;
    mc_in[24 +: 8] = 8'd11;
    mp_in[24 +: 8] = 8'd12;
    req = 4'b1001;
    traffic(23, 1'b0);
    chk("rr1001_ngrants", gq.size(), 3);
    if (gq.size() >= 2) begin
      chk("rr1001_first", gq[0], 3);
      chk("rr1001_second", gq[1], 0);
    end
    req = '0;
    traffic(12, 1'b0);

    maxw = 0;
    gq.delete();
    traffic(120, 1'b1);
    chk("no_starve", (maxw <= 11 * N + 1) ? 1 : 0, 1);
    chk("random_progress", (gq.size() >= 4) ? 1 : 0, 1);
    req = '0;
    traffic(12, 1'b0);

    // Asynchronous reset in the middle of an operation.
    mc_in[0 +: 8] = 8'd7;
    mp_in[0 +: 8] = 8'd7;
    req = 4'b0001;
    n = 0;
    tick();
    while (gnt == '0 && n < 30) begin tick(); n++; end
    chk("midrst_gnt", gnt, 1);
    req = '0;
    repeat (4) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    chk("midrst_no_done", done, 0);
    tick();
    chk("midrst_no_done2", done, 0);
    rst_n = 1'b1;
    model_ptr = 0;
    held_prod = '0;
    resync();
    single(3, 8'd7, 8'd7, "post_rst_7x7");
    traffic(20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one 8-bit signed Booth `multiplier` instance among N requesters.
- Accepts operand pairs from each requester and sequences the multiplier's start/busy protocol.
- Captures the 16-bit product at the only valid sample point and returns it to the winning requester with a done pulse.
- Sits between client datapaths and the multiplier; clients never drive the multiplier directly.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- IDW, 2, width of requester index (ceil(log2(N)), min 1)

Ports:
- clk  in  1  rising-edge clock, shared with the multiplier instance
- rst_n  in  1  asynchronous active-low reset
- req  in  N  per-requester request level; held high with operands stable until matching gnt
- mc_in  in  8*N  multiplicand of requester i at bits [8i+7:8i], two's complement
- mp_in  in  8*N  multiplier of requester i at bits [8i+7:8i], two's complement
- gnt  out  N  one-hot, one-cycle pulse: operands of that requester latched
- done  out  N  one-hot, one-cycle pulse: prod_out valid for that requester
- done_id  out  IDW  index of requester owning prod_out
- prod_out  out  16  signed product, held until next done
- arb_busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - If any req is set, pick the winner round-robin: the first set bit at or after rr_ptr, wrapping.
  - Latch mc/mp of the winner into operand registers.
  - Register gnt[winner]=1 and cur_id=winner.
  - Set rr_ptr = winner+1 mod N.
  - Go to LOAD.
  - No req: stay in IDLE, all pulses 0.
- LOAD: drive the multiplier's start=1 with the latched operands on mc/mp; go to RUN unconditionally. busy is ignored in LOAD, since it is stale or X from the previous op or power-up.
- RUN:
  - start=0.
  - Count steps 0..7 in an internal 4-bit step counter.
  - When the multiplier's busy==0 and the step counter == 8, capture prod into prod_out, register done[cur_id]=1 and done_id=cur_id, and go to IDLE.
  - If busy==0 but the step counter != 8, or the step counter reaches 9: sticky error bit err set, product still captured. This is a verification hook, not a port.
- Capture is mandatory on the first busy-low cycle. The multiplier keeps stepping while start is low, and its 4-bit counter wraps after 8 further cycles, corrupting prod. prod_out must never be re-sampled after that.
- The multiplier has no reset. Its contents before the first LOAD are don't-care and never reach prod_out.
- Arithmetic: prod_out = signed(mc)*signed(mp), exact in 16 bits for all inputs, including -128*-128 = 16384.
- A req dropped before gnt is a protocol violation; behaviour is undefined.
- req may stay high after gnt to queue a new operation; it is re-arbitrated at the next IDLE.

## Timing
- Reset, asynchronous, any state: state=IDLE, rr_ptr=0, gnt=0, done=0, done_id=0, prod_out=0, arb_busy=0, err=0, step counter=0. A reset mid-RUN aborts the operation with no done; the next LOAD reloads the multiplier.
- Edge E0 (IDLE, req seen): gnt pulses during cycle E0..E1.
- E1: multiplier loads (start high during LOAD).
- E2..E9: eight Booth steps; busy falls after E9.
- E10: capture; done pulses during E10..E11, state=IDLE.
- Grant-to-done latency is 10 cycles.
- Earliest next gnt edge is E11, so back-to-back throughput is one product per 11 cycles.
- A req arriving while arb_busy=1 waits; it is never granted in LOAD or RUN.
- Simultaneous reqs: exactly one gnt per IDLE decision; losers keep requesting.
- done for operation k and gnt for operation k+1 never occur in the same cycle.

## Test plan
- Single requester 0, mc=3, mp=17: gnt[0] at E0, done[0] at E10, prod_out=51, done_id=0.
- Requester 2, mc=-5 (0xFB), mp=6: prod_out=0xFFE2 (-30). Then mc=-128, mp=-128: prod_out=16384 (0x4000).
- All four req high from reset, operands i*7 and 7 (i=0..3):
  - grants in order 0,1,2,3, then 0 again.
  - gnt spaced 11 cycles apart.
  - products 0, 49, 98, 147 with matching done_id.
- rr_ptr=2 with req=0b1001: grant goes to 3, then 0; no requester starved over 100 random-req cycles.
- Assert rst_n low at E5 of an operation:
  - all outputs read 0 immediately (asynchronous), no done.
  - after release, a new 7*7 request completes with 49 at latency 10.
- Hold the result 20 cycles after done with no req: prod_out stays stable despite the multiplier's internal counter wrap, and err=0 throughout.
